// File: rtl/tap_ir_ctrl_pkg.sv
// Shared JTAG TAP definitions: state encoding, IR capture pattern, opcodes and
// data-register select codes.
package tap_ir_ctrl_pkg;

   // IEEE 1149.1 reference encoding.
   typedef enum logic [3:0] {
      EX2_DR = 4'h0,
      EX1_DR = 4'h1,
      SH_DR  = 4'h2,
      PA_DR  = 4'h3,
      SEL_IR = 4'h4,
      UPD_DR = 4'h5,
      CAP_DR = 4'h6,
      SEL_DR = 4'h7,
      EX2_IR = 4'h8,
      EX1_IR = 4'h9,
      SH_IR  = 4'hA,
      PA_IR  = 4'hB,
      RTI    = 4'hC,
      UPD_IR = 4'hD,
      CAP_IR = 4'hE,
      TLR    = 4'hF
   } tap_state_e;

   // The low two bits are fixed by 1149.1; upper bits are zero-filled to the IR width.
   localparam logic [1:0] IR_CAPTURE = 2'b01;

   localparam logic [4:0] OP_EXTEST = 5'h00;
   localparam logic [4:0] OP_IDCODE = 5'h01;
   localparam logic [4:0] OP_SAMPLE = 5'h02;
   localparam logic [4:0] OP_BYPASS = 5'h1F;

   typedef enum logic [1:0] {
      SEL_BYPASS = 2'd0,
      SEL_IDCODE = 2'd1,
      SEL_BSR    = 2'd2
   } dr_sel_e;

endpackage

// File: rtl/tap_ir_ctrl_fsm.sv
// 16-state TAP controller: state register, tms-driven next state and
// state-only strobe decode.
module tap_fsm
   import tap_ir_ctrl_pkg::*;
(
   input  logic       tck,
   input  logic       trst,
   input  logic       tms,
   output tap_state_e state,
   output logic       tlr,
   output logic       capture_dr,
   output logic       shift_dr,
   output logic       update_dr
);

   tap_state_e nxt;

   always_ff @(posedge tck) begin
      if (trst) state <= TLR;
      else      state <= nxt;
   end

   always_comb begin
      nxt        = state;
      tlr        = 1'b0;
      capture_dr = 1'b0;
      shift_dr   = 1'b0;
      update_dr  = 1'b0;
      unique case (state)
         TLR:     nxt = tms ? TLR    : RTI;
         RTI:     nxt = tms ? SEL_DR : RTI;
         SEL_DR:  nxt = tms ? SEL_IR : CAP_DR;
         CAP_DR:  nxt = tms ? EX1_DR : SH_DR;
         SH_DR:   nxt = tms ? EX1_DR : SH_DR;
         EX1_DR:  nxt = tms ? UPD_DR : PA_DR;
         PA_DR:   nxt = tms ? EX2_DR : PA_DR;
         EX2_DR:  nxt = tms ? UPD_DR : SH_DR;
         UPD_DR:  nxt = tms ? SEL_DR : RTI;
         SEL_IR:  nxt = tms ? TLR    : CAP_IR;
         CAP_IR:  nxt = tms ? EX1_IR : SH_IR;
         SH_IR:   nxt = tms ? EX1_IR : SH_IR;
         EX1_IR:  nxt = tms ? UPD_IR : PA_IR;
         PA_IR:   nxt = tms ? EX2_IR : PA_IR;
         EX2_IR:  nxt = tms ? UPD_IR : SH_IR;
         UPD_IR:  nxt = tms ? SEL_DR : RTI;
         default: nxt = TLR;
      endcase
      // Strobes look at the registered state only so they never glitch with tms.
      tlr        = (state == TLR);
      capture_dr = (state == CAP_DR);
      shift_dr   = (state == SH_DR);
      update_dr  = (state == UPD_DR);
   end

endmodule

// File: rtl/tap_ir_ctrl.sv
// TAP controller top: FSM plus the instruction register shift/update path and
// the registered tdo/tdo_oe mux.
module tap_ir_ctrl
   import tap_ir_ctrl_pkg::*;
#(
   parameter int               width     = 5,
   parameter logic [width-1:0] idcode_op = width'(5'h01)
) (
   input  logic             tck,
   input  logic             trst,
   input  logic             tms,
   input  logic             tdi,
   input  logic             dr_tdo,
   output logic             tdo,
   output logic             tdo_oe,
   output logic [width-1:0] ir_out,
   output logic [3:0]       state,
   output logic             tlr,
   output logic             capture_dr,
   output logic             shift_dr,
   output logic             update_dr
);

   localparam logic [width-1:0] IR_CAP = {{(width-2){1'b0}}, IR_CAPTURE};

   tap_state_e       st;
   logic [width-1:0] ir_sh;

   tap_fsm u_fsm (
      .tck        (tck),
      .trst       (trst),
      .tms        (tms),
      .state      (st),
      .tlr        (tlr),
      .capture_dr (capture_dr),
      .shift_dr   (shift_dr),
      .update_dr  (update_dr)
   );

   assign state = st;

   always_ff @(posedge tck) begin
      if (trst) begin
         ir_sh  <= IR_CAP;
         ir_out <= idcode_op;
         tdo    <= 1'b0;
         tdo_oe <= 1'b0;
      end else begin
         // Exit/pause states fall through to default and hold the shifter.
         unique case (st)
            CAP_IR:  ir_sh <= IR_CAP;
            SH_IR:   ir_sh <= {tdi, ir_sh[width-1:1]};
            default: ir_sh <= ir_sh;
         endcase

         if (st == TLR)         ir_out <= idcode_op;
         else if (st == UPD_IR) ir_out <= ir_sh;

         if (st == SH_IR)      tdo <= ir_sh[0];
         else if (st == SH_DR) tdo <= dr_tdo;
         else                  tdo <= 1'b0;

         tdo_oe <= (st == SH_IR) | (st == SH_DR);
      end
   end

endmodule

// File: tb/tb_tap_ir_ctrl.sv
// Directed vector bench for tap_ir_ctrl: reset, IR scan, pause, mid-shift
// reset, DR path and TLR recovery from a table, then tms=1 recovery walks.
module tb_tap_ir_ctrl;
   import tap_ir_ctrl_pkg::*;

   logic       tck = 1'b0;
   logic       trst, tms, tdi, dr_tdo;
   logic       tdo, tdo_oe, tlr, capture_dr, shift_dr, update_dr;
   logic [4:0] ir_out;
   logic [3:0] state;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic       trst, tms, tdi, dr;
      tap_state_e st;
      logic       tdo, oe;
      int         ir;   // -1: don't care
      int         sh;   // -1: don't care
   } vec_t;

   vec_t vq[$];

   tap_ir_ctrl #(.width(5), .idcode_op(5'h01)) dut (
      .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .dr_tdo(dr_tdo),
      .tdo(tdo), .tdo_oe(tdo_oe), .ir_out(ir_out), .state(state),
      .tlr(tlr), .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr)
   );

   always #5 tck = ~tck;

   task automatic add(input logic r, m, d, dr, input tap_state_e st,
                      input logic o, e, input int ir, input int sh);
      vec_t v;
      v.trst = r; v.tms = m; v.tdi = d; v.dr = dr; v.st = st;
      v.tdo = o; v.oe = e; v.ir = ir; v.sh = sh;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s vec %0d: got %0h, want %0h", name, idx, act, exp);
      end
   endtask

   task automatic step(input logic r, m, d, dr);
      trst = r; tms = m; tdi = d; dr_tdo = dr;
      @(posedge tck);
      #1;
      n_vec++;
   endtask

   initial begin
      trst = 1'b1; tms = 1'b1; tdi = 1'b0; dr_tdo = 1'b0;
      #1;

      // reset
      add(1,1,0,0, TLR,   0,0, 'h01, 'h01);
      add(1,1,0,0, TLR,   0,0, 'h01, 'h01);
      add(0,1,0,0, TLR,   0,0, 'h01, -1);
      // IR scan of all ones
      add(0,0,0,0, RTI,   0,0, 'h01, -1);
      add(0,1,0,0, SEL_DR,0,0, 'h01, -1);
      add(0,1,0,0, SEL_IR,0,0, 'h01, -1);
      add(0,0,0,0, CAP_IR,0,0, 'h01, -1);
      add(0,0,0,0, SH_IR, 0,0, 'h01, 'h01);
      add(0,0,1,0, SH_IR, 1,1, 'h01, 'h10);
      add(0,0,1,0, SH_IR, 0,1, 'h01, 'h18);
      add(0,0,1,0, SH_IR, 0,1, 'h01, 'h1C);
      add(0,0,1,0, SH_IR, 0,1, 'h01, 'h1E);
      add(0,1,1,0, EX1_IR,0,1, 'h01, 'h1F);
      add(0,1,0,0, UPD_IR,0,0, 'h01, 'h1F);
      add(0,0,0,0, RTI,   0,0, 'h1F, -1);
      // reset mid-shift, trst wins over tms=0
      add(0,1,0,0, SEL_DR,0,0, 'h1F, -1);
      add(0,1,0,0, SEL_IR,0,0, 'h1F, -1);
      add(0,0,0,0, CAP_IR,0,0, 'h1F, -1);
      add(0,0,0,0, SH_IR, 0,0, 'h1F, 'h01);
      add(0,0,1,0, SH_IR, 1,1, 'h1F, 'h10);
      add(0,0,1,0, SH_IR, 0,1, 'h1F, 'h18);
      add(1,0,1,0, TLR,   0,0, 'h01, 'h01);
      add(0,0,0,0, RTI,   0,0, 'h01, -1);
      // 3 bits, pause 4 cycles with tdi toggling, 2 more bits: tdi 1,0,1,1,0
      add(0,1,0,0, SEL_DR,0,0, 'h01, -1);
      add(0,1,0,0, SEL_IR,0,0, 'h01, -1);
      add(0,0,0,0, CAP_IR,0,0, 'h01, -1);
      add(0,0,0,0, SH_IR, 0,0, 'h01, 'h01);
      add(0,0,1,0, SH_IR, 1,1, 'h01, 'h10);
      add(0,0,0,0, SH_IR, 0,1, 'h01, 'h08);
      add(0,1,1,0, EX1_IR,0,1, 'h01, 'h14);
      add(0,0,1,0, PA_IR, 0,0, 'h01, 'h14);
      add(0,0,1,0, PA_IR, 0,0, 'h01, 'h14);
      add(0,0,0,0, PA_IR, 0,0, 'h01, 'h14);
      add(0,0,1,0, PA_IR, 0,0, 'h01, 'h14);
      add(0,1,1,0, EX2_IR,0,0, 'h01, 'h14);
      add(0,0,1,0, SH_IR, 0,0, 'h01, 'h14);
      add(0,0,1,0, SH_IR, 0,1, 'h01, 'h1A);
      add(0,1,0,0, EX1_IR,0,1, 'h01, 'h0D);
      add(0,1,0,0, UPD_IR,0,0, 'h01, 'h0D);
      add(0,0,0,0, RTI,   0,0, 'h0D, -1);
      // DR path, then tms=1 x5 from SH_DR back to TLR
      add(0,1,0,0, SEL_DR,0,0, 'h0D, -1);
      add(0,0,0,1, CAP_DR,0,0, 'h0D, -1);
      add(0,0,0,1, SH_DR, 0,0, 'h0D, -1);
      add(0,0,0,1, SH_DR, 1,1, 'h0D, -1);
      add(0,0,0,0, SH_DR, 0,1, 'h0D, -1);
      add(0,0,0,1, SH_DR, 1,1, 'h0D, -1);
      add(0,1,0,0, EX1_DR,0,1, 'h0D, -1);
      add(0,1,0,1, UPD_DR,0,0, 'h0D, -1);
      add(0,1,0,1, SEL_DR,0,0, 'h0D, -1);
      add(0,1,0,0, SEL_IR,0,0, 'h0D, -1);
      add(0,1,0,0, TLR,   0,0, 'h0D, -1);
      add(0,1,0,0, TLR,   0,0, 'h01, -1);
      add(0,1,0,0, TLR,   0,0, 'h01, -1);

      foreach (vq[i]) begin
         step(vq[i].trst, vq[i].tms, vq[i].tdi, vq[i].dr);
         chk("xcheck", i, 32'($isunknown({tdo, tdo_oe, ir_out, state, tlr, capture_dr, shift_dr, update_dr})), 0);
         chk("state",  i, 32'(state), 32'(vq[i].st));
         chk("tdo",    i, 32'(tdo),    32'(vq[i].tdo));
         chk("tdo_oe", i, 32'(tdo_oe), 32'(vq[i].oe));
         chk("strobes", i, 32'({tlr, capture_dr, shift_dr, update_dr}),
             32'({vq[i].st == TLR, vq[i].st == CAP_DR, vq[i].st == SH_DR, vq[i].st == UPD_DR}));
         if (vq[i].ir >= 0) chk("ir_out", i, 32'(ir_out), 32'(vq[i].ir));
         if (vq[i].sh >= 0) chk("ir_sh",  i, 32'(dut.ir_sh), 32'(vq[i].sh));
      end

      // Arbitrary tms walks, then five tms=1 must land in TLR and stay there.
      for (int n = 0; n < 10; n++) begin
         int len = 2 + n;
         for (int k = 0; k < len; k++) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
         for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
         chk("recover_state", 1000 + n, 32'(state), 32'(TLR));
         chk("recover_tlr",   1000 + n, 32'(tlr), 1);
         step(1'b0, 1'b1, 1'b0, 1'b0);
         chk("hold_tlr",  1000 + n, 32'(state), 32'(TLR));
         chk("hold_ir",   1000 + n, 32'(ir_out), 32'h01);
         chk("hold_oe",   1000 + n, 32'(tdo_oe), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
